// File: rtl/avmm_reg_master.sv
// Avalon-MM register master: turns one local command at a time into a single
// write/read bus transaction, with waitrequest stall, optional readdatavalid and a timeout.
module avmm_reg_master #(
  parameter int B       = 32,
  parameter int AW      = 4,
  parameter int USE_RDV = 1,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [B-1:0]  cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [B-1:0]  rsp_data,
  output logic          rsp_err,
  output logic [AW-1:0] address,
  output logic          write_n,
  output logic          read_n,
  output logic [B-1:0]  writedata,
  input  logic          waitrequest,
  input  logic [B-1:0]  readdata,
  input  logic          readdatavalid
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RDV, S_RESP} state_t;

  localparam int TW = 16;

  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic            r_cmd_ready;
  logic            r_rsp_valid;
  logic [B-1:0]    r_rsp_data;
  logic            r_rsp_err;
  logic [AW-1:0]   r_address;
  logic            r_write_n;
  logic            r_read_n;
  logic [B-1:0]    r_writedata;

  logic [TW-1:0]   w_timer_inc;
  logic            w_expired;

  // Saturating counter; ">=" keeps expiry reachable even if the counter passed the limit.
  assign w_timer_inc = (r_timer == {TW{1'b1}}) ? r_timer : r_timer + 1'b1;
  assign w_expired   = (r_timer >= TW'(TIMEOUT - 1));

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign address   = r_address;
  assign write_n   = r_write_n;
  assign read_n    = r_read_n;
  assign writedata = r_writedata;

  // NOTE: state and all outputs use non-blocking assignments so every register
  // samples the pre-edge values and the block order does not matter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_address   <= '0;
      r_write_n   <= 1'b1;
      r_read_n    <= 1'b1;
      r_writedata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_address   <= cmd_addr;
            r_writedata <= cmd_wdata;
            r_timer     <= '0;
            r_cmd_ready <= 1'b0;
            if (cmd_write) begin
              r_write_n <= 1'b0;
              r_state   <= S_WR;
            end else begin
              r_read_n <= 1'b0;
              r_state  <= S_RD;
            end
          end
        end

        S_WR: begin
          r_timer <= w_timer_inc;
          if (!waitrequest || w_expired) begin
            r_write_n   <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_err   <= waitrequest;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end

        S_RD: begin
          r_timer <= w_timer_inc;
          if (!waitrequest) begin
            r_read_n <= 1'b1;
            // With USE_RDV=1 a readdatavalid coincident with the accept cycle skips RDV.
            if (USE_RDV == 0 || readdatavalid) begin
              r_rsp_data  <= readdata;
              r_rsp_err   <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_state <= S_RDV;
            end
          end else if (w_expired) begin
            r_read_n    <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end

        S_RDV: begin
          r_timer <= w_timer_inc;
          if (readdatavalid) begin
            r_rsp_data  <= readdata;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (w_expired) begin
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_write_n   <= 1'b1;
          r_read_n    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avmm_reg_master.sv
// Bench for avmm_reg_master: a per-cycle slave model drives the bus, and a
// scoreboard queue holds the expected response of every issued command.
module tb_avmm_reg_master;

  localparam int B       = 32;
  localparam int AW      = 4;
  localparam int TIMEOUT = 8;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [B-1:0]  cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [B-1:0]  rsp_data;
  logic          rsp_err;
  logic [AW-1:0] address;
  logic          write_n;
  logic          read_n;
  logic [B-1:0]  writedata;
  logic          waitrequest;
  logic [B-1:0]  readdata;
  logic          readdatavalid;

  typedef struct {
    logic [B-1:0] data;
    logic         err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  avmm_reg_master #(
    .B(B), .AW(AW), .USE_RDV(1), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .address(address), .write_n(write_n), .read_n(read_n), .writedata(writedata),
    .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted response is popped and compared.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  // One command end to end. wr_wait: waitrequest-high cycles from the first strobe cycle.
  // rdv_at: readdatavalid this many cycles after the waitrequest-low cycle (-1 = never).
  task automatic run_txn(input string name, input bit wr, input logic [AW-1:0] addr,
                         input logic [B-1:0] wdata, input int wr_wait, input int rdv_at,
                         input logic [B-1:0] rdata, input bit to, input int exp_low,
                         input int exp_lat, input int hold);
    rsp_t e;
    int   t;
    int   low;
    int   other;
    bit   done;
    e.err  = to;
    e.data = (wr || to) ? '0 : rdata;
    exp_q.push_back(e);

    @(posedge clk); #1;
    rsp_ready = (hold == 0);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    @(negedge clk);
    check({name, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_addr  = ~addr;
    cmd_wdata = ~wdata;

    t = 0; low = 0; other = 0; done = 0;
    while (!done && t < 50) begin
      waitrequest   = (t < wr_wait);
      readdatavalid = (!wr && rdv_at >= 0 && t == wr_wait + rdv_at);
      readdata      = readdatavalid ? rdata : 32'hDEAD_BEEF;
      @(negedge clk);
      if (rsp_valid) begin
        done = 1;
      end else begin
        check({name, "_strobe_excl"}, 32'(write_n | read_n), 32'd1);
        if (wr ? !write_n : !read_n) begin
          low++;
          check({name, "_addr"}, 32'(address), 32'(addr));
          if (wr) check({name, "_wdata"}, writedata, wdata);
        end
        if (wr ? !read_n : !write_n) other++;
        @(posedge clk); #1;
        t++;
      end
    end
    waitrequest   = 1'b1;
    readdatavalid = 1'b0;
    readdata      = '0;
    check({name, "_latency"}, 32'(t), 32'(exp_lat));
    check({name, "_strobe_cycles"}, 32'(low), 32'(exp_low));
    check({name, "_wrong_strobe"}, 32'(other), 32'd0);
    check({name, "_strobe_released"}, 32'(write_n & read_n), 32'd1);

    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check({name, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({name, "_hold_data"}, rsp_data, e.data);
      check({name, "_hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check({name, "_idle_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({name, "_idle_rsp_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    cmd_valid     = 1'b0;
    cmd_write     = 1'b0;
    cmd_addr      = '0;
    cmd_wdata     = '0;
    rsp_ready     = 1'b1;
    waitrequest   = 1'b1;
    readdata      = '0;
    readdatavalid = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_strobes", 32'({write_n, read_n}), 32'd3);
    check("rst_address", 32'(address), 32'd0);
    check("rst_writedata", writedata, 32'd0);
    reset = 1'b0;

    //       name        wr addr   wdata          wait rdv  rdata          to  low lat hold
    run_txn("wr_fast",   1, 4'h0, 32'hA5A5_0001,    0, -1, 32'h0,         0,  1,  1, 0);
    run_txn("wr_wait3",  1, 4'h3, 32'h0BAD_F00D,    3, -1, 32'h0,         0,  4,  4, 0);
    run_txn("rd_rdv2",   0, 4'h0, 32'h0,            0,  2, 32'h1234_5678, 0,  1,  3, 0);
    run_txn("rd_rdv0",   0, 4'h9, 32'h0,            2,  0, 32'h8765_4321, 0,  3,  3, 0);
    run_txn("wr_tmo",    1, 4'h2, 32'hFFFF_0000, 1000, -1, 32'h0,         1,  8,  8, 0);
    run_txn("wr_edge",   1, 4'hF, 32'h0000_FFFF,    7, -1, 32'h0,         0,  8,  8, 0);
    run_txn("rd_tmo",    0, 4'h1, 32'h0,         1000, -1, 32'h5555_AAAA, 1,  8,  8, 0);
    run_txn("rdv_tmo",   0, 4'h4, 32'h0,            0, -1, 32'h5555_AAAA, 1,  1,  8, 0);
    run_txn("rd_hold",   0, 4'h6, 32'h0,            1,  1, 32'hCAFE_F00D, 0,  2,  3, 5);

    // Reset in the middle of a stalled read: everything returns to idle at once.
    @(posedge clk); #1;
    cmd_valid   = 1'b1;
    cmd_write   = 1'b0;
    cmd_addr    = 4'h5;
    waitrequest = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_read_n_before", 32'(read_n), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_read_n", 32'(read_n), 32'd1);
    check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    reset       = 1'b0;
    waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
    waitrequest = 1'b1;

    run_txn("post_rst",  1, 4'h7, 32'h1357_9BDF,    1, -1, 32'h0,         0,  2,  2, 0);

    repeat (2) @(posedge clk);
    check("rsp_missing", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
